// File: rtl/shim_ads816x_pkg.sv
// Shared constants for the ADS816x shim: sequencer state encoding, OTF command width
// and ADC model identifiers.
package shim_ads816x_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_XFER    = 3'd3;
    localparam logic [2:0] S_CS_HIGH = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    localparam int OTF_CMD_BITS = 16;

    localparam logic [7:0] ADS8166_ID = 8'h66;
    localparam logic [7:0] ADS8167_ID = 8'h67;
    localparam logic [7:0] ADS8168_ID = 8'h68;

endpackage

// File: rtl/shim_ads816x_cs_timer.sv
// Loadable down-counter with zero flag; used for the n_cs high gap and the xfer watchdog.
module shim_ads816x_cs_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/shim_ads816x_adc_sched.sv
// ADS816x channel sequencer: timing-calc handshake, OTF command framing with n_cs gap.
// Optional xfer_done watchdog enabled by defining SHIM_ADS816X_ADC_SCHED_TIMEOUT_EN.
module shim_ads816x_adc_sched
    import shim_ads816x_pkg::*;
#(
    parameter int CMD_BITS       = OTF_CMD_BITS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                spi_en,
    input  logic [31:0]         spi_clk_freq_hz,
    output logic                calc,
    output logic [31:0]         calc_freq_hz,
    input  logic                calc_done,
    input  logic                calc_lock_viol,
    input  logic [7:0]          n_cs_high_time,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CMD_BITS-1:0] cmd_data,
    output logic                xfer_start,
    output logic [CMD_BITS-1:0] xfer_word,
    input  logic                xfer_done,
    output logic                n_cs,
    output logic                ready,
    output logic                err_lock_viol,
    output logic                err_timeout,
    output logic [31:0]         xfer_count,
    output logic [2:0]          state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0] state_r;
    logic [2:0] state_nxt;
    logic       set_lock;
    logic       set_timeout;
    logic       count_en;
    logic       cs_zero;
    logic       timeout_hit;
    logic       xfer_entry;
    logic       clear_err;

    assign calc_freq_hz = spi_clk_freq_hz;
    assign state        = state_r;

    // cmd handshake: a word transfers on a clk edge where cmd_valid && cmd_ready.
    // cmd_ready is offered in S_READY and in the last gap cycle of S_CS_HIGH (so a
    // waiting word keeps n_cs high for exactly n_cs_high_time+1 cycles), and is
    // withheld whenever this cycle is being pre-empted by spi_en=0 or a lock violation.
    assign cmd_ready = spi_en && !calc_lock_viol &&
                       ((state_r == S_READY) || ((state_r == S_CS_HIGH) && cs_zero));

    assign xfer_entry = (state_nxt == S_XFER) && (state_r != S_XFER);
    assign clear_err  = (state_r == S_ERR) && !spi_en;

    always_comb begin
        state_nxt   = state_r;
        set_lock    = 1'b0;
        set_timeout = 1'b0;
        count_en    = 1'b0;
        if (state_r == S_ERR) begin
            if (!spi_en) state_nxt = S_IDLE;
        end else if (!spi_en) begin
            state_nxt = S_IDLE;
        end else if ((state_r != S_IDLE) && calc_lock_viol) begin
            state_nxt = S_ERR;
            set_lock  = 1'b1;
        end else if (timeout_hit) begin
            state_nxt   = S_ERR;
            set_timeout = 1'b1;
        end else begin
            case (state_r)
                S_IDLE:    if (!err_lock_viol && !err_timeout) state_nxt = S_CALC;
                S_CALC:    if (calc_done) state_nxt = S_READY;
                S_READY:   if (cmd_valid) state_nxt = S_XFER;
                S_XFER: begin
                    if (xfer_done) begin
                        state_nxt = S_CS_HIGH;
                        count_en  = 1'b1;
                    end
                end
                S_CS_HIGH: begin
                    if (cs_zero && cmd_valid) state_nxt = S_XFER;
                    else if (cs_zero)         state_nxt = S_READY;
                end
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // n_cs_high_time is captured at xfer_done; later changes affect only later frames.
    shim_ads816x_cs_timer #(.W(8)) u_cs_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load       (count_en),
        .load_value (n_cs_high_time),
        .en         (state_r == S_CS_HIGH),
        .zero       (cs_zero)
    );

`ifdef SHIM_ADS816X_ADC_SCHED_TIMEOUT_EN
    logic wd_zero;

    shim_ads816x_cs_timer #(.W(32)) u_watchdog (
        .clk        (clk),
        .resetn     (resetn),
        .load       (xfer_entry),
        .load_value (32'(TIMEOUT_CYCLES - 1)),
        .en         (state_r == S_XFER),
        .zero       (wd_zero)
    );

    assign timeout_hit = (state_r == S_XFER) && wd_zero && !xfer_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_timeout <= 1'b0;
        end else if (set_timeout) begin
            err_timeout <= 1'b1;
        end else if (clear_err) begin
            err_timeout <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Control outputs are registered from the next state so n_cs and calc never glitch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r       <= S_IDLE;
            calc          <= 1'b0;
            n_cs          <= 1'b1;
            ready         <= 1'b0;
            xfer_start    <= 1'b0;
            xfer_word     <= '0;
            err_lock_viol <= 1'b0;
            xfer_count    <= '0;
        end else begin
            state_r    <= state_nxt;
            calc       <= state_nxt inside {S_CALC, S_READY, S_XFER, S_CS_HIGH};
            n_cs       <= (state_nxt != S_XFER);
            ready      <= (state_nxt == S_READY);
            xfer_start <= xfer_entry;
            if (xfer_entry) xfer_word <= cmd_data;
            if (set_lock) begin
                err_lock_viol <= 1'b1;
            end else if (clear_err) begin
                err_lock_viol <= 1'b0;
            end
            if (count_en) xfer_count <= xfer_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_shim_ads816x_adc_sched.sv
// Self-checking bench for shim_ads816x_adc_sched: per-cycle vector table plus
// directed multi-cycle sequences (gap timing, lock violation, disable, wrap, timeout).
module tb_shim_ads816x_adc_sched;
    import shim_ads816x_pkg::*;

`ifdef SHIM_ADS816X_ADC_SCHED_TIMEOUT_EN
    localparam int TB_TIMEOUT = 64;
`else
    localparam int TB_TIMEOUT = 1024;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        resetn;
    logic        spi_en;
    logic [31:0] spi_clk_freq_hz;
    logic        calc;
    logic [31:0] calc_freq_hz;
    logic        calc_done;
    logic        calc_lock_viol;
    logic [7:0]  n_cs_high_time;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        xfer_start;
    logic [15:0] xfer_word;
    logic        xfer_done;
    logic        n_cs;
    logic        ready;
    logic        err_lock_viol;
    logic        err_timeout;
    logic [31:0] xfer_count;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shim_ads816x_adc_sched #(.CMD_BITS(16), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .spi_en          (spi_en),
        .spi_clk_freq_hz (spi_clk_freq_hz),
        .calc            (calc),
        .calc_freq_hz    (calc_freq_hz),
        .calc_done       (calc_done),
        .calc_lock_viol  (calc_lock_viol),
        .n_cs_high_time  (n_cs_high_time),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .xfer_start      (xfer_start),
        .xfer_word       (xfer_word),
        .xfer_done       (xfer_done),
        .n_cs            (n_cs),
        .ready           (ready),
        .err_lock_viol   (err_lock_viol),
        .err_timeout     (err_timeout),
        .xfer_count      (xfer_count),
        .state           (state)
    );

    typedef struct {
        logic        en;
        logic        cd;
        logic        v;
        logic        xd;
        logic [15:0] data;
        logic [2:0]  e_state;
        logic        e_calc;
        logic        e_ncs;
        logic        e_rdy;
        logic        e_start;
        logic [15:0] e_word;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic en, logic cd, logic v, logic xd, logic [15:0] data,
                                logic [2:0] es, logic ec, logic encs, logic er, logic est,
                                logic [15:0] ew, logic [31:0] ecnt);
        vec_t r;
        r.en = en; r.cd = cd; r.v = v; r.xd = xd; r.data = data;
        r.e_state = es; r.e_calc = ec; r.e_ncs = encs; r.e_rdy = er; r.e_start = est;
        r.e_word = ew; r.e_count = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_done();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int i;
        i = 0;
        while (!xfer_start && i < 100) begin
            tick();
            i++;
        end
        chk(name, 32'(xfer_start), 32'd1);
    endtask

    task automatic measure_gap(output int gap);
        gap = 0;
        for (int i = 0; i < 300 && n_cs; i++) begin
            gap++;
            tick();
        end
    endtask

    task automatic reset_check(input string tag);
        resetn = 1'b0;
        spi_en = 1'b0; calc_done = 1'b0; calc_lock_viol = 1'b0;
        cmd_valid = 1'b0; cmd_data = 16'h0; xfer_done = 1'b0;
        repeat (3) tick();
        chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
        chk({tag, "_calc"}, 32'(calc), 32'd0);
        chk({tag, "_n_cs"}, 32'(n_cs), 32'd1);
        chk({tag, "_start"}, 32'(xfer_start), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_word"}, 32'(xfer_word), 32'd0);
        chk({tag, "_err"}, 32'({err_lock_viol, err_timeout}), 32'd0);
        chk({tag, "_count"}, xfer_count, 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int gap;
        int starts;
        int xcycles;

        spi_clk_freq_hz = 32'd25_000_000;
        n_cs_high_time  = 8'd1;
        resetn          = 1'b0;
        tick();
        reset_check("rst0");
        chk("freq_pass", calc_freq_hz, 32'd25_000_000);

        // en, cd, v, xd, data -> state, calc, n_cs, ready, start, word, count
        vecs[0]  = mk(H, L, L, L, 16'h0000, S_CALC,    H, H, L, L, 16'h0000, 32'd0);
        vecs[1]  = mk(H, H, L, L, 16'h0000, S_READY,   H, H, H, L, 16'h0000, 32'd0);
        vecs[2]  = mk(H, L, H, L, 16'h1234, S_XFER,    H, L, L, H, 16'h1234, 32'd0);
        vecs[3]  = mk(H, L, H, L, 16'h5678, S_XFER,    H, L, L, L, 16'h1234, 32'd0);
        vecs[4]  = mk(H, L, H, H, 16'h5678, S_CS_HIGH, H, H, L, L, 16'h1234, 32'd1);
        vecs[5]  = mk(H, L, H, L, 16'h5678, S_CS_HIGH, H, H, L, L, 16'h1234, 32'd1);
        vecs[6]  = mk(H, L, H, L, 16'h5678, S_XFER,    H, L, L, H, 16'h5678, 32'd1);
        vecs[7]  = mk(H, L, L, H, 16'h0000, S_CS_HIGH, H, H, L, L, 16'h5678, 32'd2);
        vecs[8]  = mk(H, L, L, L, 16'h0000, S_CS_HIGH, H, H, L, L, 16'h5678, 32'd2);
        vecs[9]  = mk(H, L, L, L, 16'h0000, S_READY,   H, H, H, L, 16'h5678, 32'd2);
        vecs[10] = mk(L, L, L, L, 16'h0000, S_IDLE,    L, H, L, L, 16'h5678, 32'd2);

        for (int i = 0; i < 11; i++) begin
            spi_en = vecs[i].en; calc_done = vecs[i].cd; cmd_valid = vecs[i].v;
            xfer_done = vecs[i].xd; cmd_data = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            chk($sformatf("vec%0d_calc", i), 32'(calc), 32'(vecs[i].e_calc));
            chk($sformatf("vec%0d_n_cs", i), 32'(n_cs), 32'(vecs[i].e_ncs));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_start", i), 32'(xfer_start), 32'(vecs[i].e_start));
            chk($sformatf("vec%0d_word", i), 32'(xfer_word), 32'(vecs[i].e_word));
            chk($sformatf("vec%0d_count", i), xfer_count, vecs[i].e_count);
        end
        xfer_done = 1'b0; cmd_valid = 1'b0; calc_done = 1'b0;

        // Reset in the middle of a calc must look like power-up.
        spi_en = 1'b1;
        repeat (3) tick();
        reset_check("rst_mid");

        // Bring-up with a slow calc.
        spi_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk($sformatf("calc_wait%0d", i), 32'({calc, n_cs, ready}), 32'b110);
        end
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("calc_ready", 32'({calc, n_cs, ready}), 32'b111);
        chk("calc_cmd_ready", 32'(cmd_ready), 32'd1);

        // Back-to-back frames with a 50-cycle gap.
        n_cs_high_time = 8'd49;
        cmd_valid = 1'b1; cmd_data = 16'hA000;
        wait_start("b2b_start0");
        chk("b2b_word0", 32'(xfer_word), 32'h0000_A000);
        cmd_data = 16'hA400;
        repeat (15) tick();
        pulse_done();
        measure_gap(gap);
        chk("b2b_gap50", gap, 32'd50);
        chk("b2b_start1", 32'(xfer_start), 32'd1);
        chk("b2b_word1", 32'(xfer_word), 32'h0000_A400);
        cmd_valid = 1'b0;
        repeat (15) tick();
        pulse_done();
        chk("b2b_count", xfer_count, 32'd2);

        // Lock violation abandons the in-flight frame.
        cmd_valid = 1'b1; cmd_data = 16'hB000;
        wait_start("lock_start");
        cmd_valid = 1'b0;
        repeat (5) tick();
        calc_lock_viol = 1'b1;
        tick();
        calc_lock_viol = 1'b0;
        chk("lock_n_cs", 32'(n_cs), 32'd1);
        chk("lock_err", 32'(err_lock_viol), 32'd1);
        chk("lock_state", 32'(state), 32'(S_ERR));
        chk("lock_calc", 32'(calc), 32'd0);
        chk("lock_count", xfer_count, 32'd2);
        pulse_done();
        repeat (3) tick();
        chk("lock_hold_state", 32'(state), 32'(S_ERR));
        chk("lock_hold_count", xfer_count, 32'd2);
        spi_en = 1'b0;
        tick();
        chk("lock_clr_state", 32'(state), 32'(S_IDLE));
        chk("lock_clr_err", 32'(err_lock_viol), 32'd0);

        // Disable during the cs-high gap, then a stray xfer_done in idle.
        spi_en = 1'b1;
        tick();
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        cmd_valid = 1'b1; cmd_data = 16'hC000;
        wait_start("dis_start");
        cmd_valid = 1'b0;
        repeat (15) tick();
        pulse_done();
        chk("dis_count3", xfer_count, 32'd3);
        chk("dis_cs_high", 32'(state), 32'(S_CS_HIGH));
        repeat (5) tick();
        spi_en = 1'b0;
        tick();
        chk("dis_idle", 32'({state, calc, n_cs}), 32'({S_IDLE, 1'b0, 1'b1}));
        pulse_done();
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            starts += int'(xfer_start);
            tick();
        end
        chk("dis_stray_count", xfer_count, 32'd3);
        chk("dis_no_start", starts, 32'd0);
        spi_en = 1'b1;
        tick();
        chk("dis_recalc", 32'(calc), 32'd1);

        // xfer_done coinciding with spi_en=0 is not counted.
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        cmd_valid = 1'b1; cmd_data = 16'hD000;
        wait_start("coinc_start");
        cmd_valid = 1'b0;
        repeat (3) tick();
        spi_en = 1'b0;
        pulse_done();
        chk("coinc_state", 32'(state), 32'(S_IDLE));
        chk("coinc_count", xfer_count, 32'd3);

        // Zero gap setting and counter wrap.
        spi_en = 1'b1;
        tick();
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        n_cs_high_time = 8'd0;
        cmd_valid = 1'b1; cmd_data = 16'hE000;
        wait_start("zero_start0");
        cmd_data = 16'hE100;
        repeat (2) tick();
        pulse_done();
        measure_gap(gap);
        chk("zero_gap1", gap, 32'd1);
        chk("zero_word1", 32'(xfer_word), 32'h0000_E100);
        cmd_valid = 1'b0;
        force dut.xfer_count = 32'hFFFF_FFFF;
        tick();
        release dut.xfer_count;
        tick();
        chk("wrap_preload", xfer_count, 32'hFFFF_FFFF);
        pulse_done();
        chk("wrap_zero", xfer_count, 32'd0);

`ifdef SHIM_ADS816X_ADC_SCHED_TIMEOUT_EN
        repeat (3) tick();
        cmd_valid = 1'b1; cmd_data = 16'hF000;
        wait_start("to_start");
        cmd_valid = 1'b0;
        xcycles = 1;
        for (int i = 0; i < 200 && state == S_XFER; i++) begin
            tick();
            if (state == S_XFER) xcycles++;
        end
        chk("to_cycles", xcycles, 32'd64);
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_n_cs", 32'(n_cs), 32'd1);
        chk("to_state", 32'(state), 32'(S_ERR));
`else
        xcycles = 0;
        chk("to_tied0", 32'(err_timeout) + xcycles, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shim_ads816x_adc_sched.md
Name: shim_ads816x_adc_sched

Overview:
- Sequencer for one ADS816x ADC channel. Runs in the SPI clock domain; clk is the SPI clock.
- Drives the shim_ads816x_adc_timing_calc handshake, then issues on-the-fly (OTF) command frames from an upstream command stream to the SPI shifter.
- Frames each transfer with n_cs and enforces the calculated n_cs high time between consecutive frames.
- Sits between the ADC command FIFO and the SPI shift engine.

Parameters:
- CMD_BITS, 16, width of the OTF command word passed to the shifter.
- TIMEOUT_CYCLES, 1024, xfer_done watchdog limit in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  SPI-domain clock.
- resetn  in  1  reset.
- spi_en  in  1  level; high = run, low = return to idle.
- spi_clk_freq_hz  in  32  passed through unmodified to the timing calc (calc_freq_hz).
- calc  out  1  calculation request/hold to the timing calc.
- calc_freq_hz  out  32  equals spi_clk_freq_hz, combinational.
- calc_done  in  1  timing calc done.
- calc_lock_viol  in  1  timing calc lock violation.
- n_cs_high_time  in  8  high time in cycles minus 1, from the timing calc.
- cmd_valid  in  1  command word valid.
- cmd_ready  out  1  command word accepted.
- cmd_data  in  CMD_BITS  OTF command word.
- xfer_start  out  1  one-cycle pulse that starts the shifter.
- xfer_word  out  CMD_BITS  word to shift; held stable until xfer_done.
- xfer_done  in  1  one-cycle pulse when the shifter finishes.
- n_cs  out  1  ADC chip select, active low.
- ready  out  1  high in S_READY.
- err_lock_viol  out  1  sticky lock-violation error.
- err_timeout  out  1  sticky timeout error; tied 0 without the optional feature.
- xfer_count  out  32  completed transfers; wraps at 2^32.

Behaviour:
Reset and reset mid-operation:
- Reset (resetn=0 at a clk edge) values: state S_IDLE, calc=0, n_cs=1, xfer_start=0, cmd_ready=0, ready=0, xfer_word=0, errors=0, xfer_count=0, cs counter=0.
- Reset mid-operation behaves identically to power-up reset.

States:
- S_IDLE: calc=0, n_cs=1. If spi_en=1 and no error is set, go to S_CALC next cycle.
- S_CALC: calc=1. calc_done=1 → S_READY. calc_lock_viol=1 → set err_lock_viol, go to S_ERR.
- S_READY: cmd_ready=ready=1. On cmd_valid&&cmd_ready:
  - latch cmd_data into xfer_word;
  - drive n_cs=0 and xfer_start=1 in the following cycle;
  - go to S_XFER.
- S_XFER: n_cs=0, cmd_ready=0. On xfer_done:
  - n_cs=1 next cycle;
  - increment xfer_count;
  - load cs counter with n_cs_high_time;
  - go to S_CS_HIGH.
- S_CS_HIGH: n_cs=1. Counter decrements each cycle; at counter==0 go to S_READY.
  - n_cs is high exactly n_cs_high_time+1 cycles between the n_cs rising edge and the next possible n_cs falling edge, counting the S_READY acceptance cycle as zero extra when cmd_valid is already high.
- S_ERR: calc=0, n_cs=1, ready=0. Stay until spi_en=0, then go to S_IDLE and clear errors.

Rules that apply in every non-idle state:
- calc stays 1 from S_CALC through S_READY, S_XFER and S_CS_HIGH, so the timing calc keeps monitoring frequency changes.
- calc_lock_viol=1 in any of those states → err_lock_viol=1, next state S_ERR.
  - In S_XFER the in-flight transfer is abandoned: n_cs=1 immediately and xfer_count is not incremented.
- spi_en=0 in any state other than S_ERR → S_IDLE next cycle, calc=0, n_cs=1.
  - An in-flight transfer is abandoned and not counted.
  - A late xfer_done arriving in S_IDLE is ignored.

Priority and boundary cases:
- Priority when events coincide: reset > spi_en=0 > lock_viol > timeout > normal progression.
- xfer_done in the same cycle as spi_en=0: transfer is not counted.
- First transfer after S_CALC starts immediately, with no cs-high wait.
- n_cs_high_time is sampled at xfer_done, so a value updated later applies only to subsequent frames.
- n_cs_high_time=0 gives a 1-cycle n_cs high gap.

Optional Feature:
- Macro: SHIM_ADS816X_ADC_SCHED_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles in S_XFER, cleared on entry.
  - Reaching TIMEOUT_CYCLES without xfer_done → err_timeout=1, n_cs=1, go to S_ERR.
- Undefined: no counter is built, err_timeout is constant 0, S_XFER waits indefinitely.

Decomposition:
- Shared package shim_ads816x_pkg holds:
  - state encoding constants (3-bit: IDLE=0, CALC=1, READY=2, XFER=3, CS_HIGH=4, ERR=5);
  - OTF_CMD_BITS=16;
  - the ADS model ID constants.
- One natural sub-module: shim_ads816x_cs_timer, a loadable down-counter with load value, load strobe and zero flag, reused for the cs-high count and the watchdog.

Test Plan:
- Reset, then spi_en=1; calc_done after 30 cycles → calc=1 from cycle 1, ready=1 one cycle after calc_done, n_cs=1 throughout.
- n_cs_high_time=49; two back-to-back commands 0xA000, 0xA400 with cmd_valid held; xfer_done 16 cycles after each xfer_start:
  - xfer_word matches each command;
  - n_cs high exactly 50 cycles between frames;
  - xfer_count=2.
- calc_lock_viol pulsed mid-S_XFER → n_cs=1 next cycle, err_lock_viol=1, xfer_count unchanged, calc=0; spi_en low clears the error and returns to S_IDLE.
- spi_en dropped during S_CS_HIGH and xfer_done pulsed while in S_IDLE → no count change, no xfer_start; re-enable → calc re-asserted.
- With SHIM_ADS816X_ADC_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, xfer_done withheld → err_timeout=1 at cycle 64 of S_XFER, n_cs=1, state S_ERR.
- n_cs_high_time=0 with cmd_valid held → 1-cycle n_cs high gap; xfer_count wraps from 0xFFFFFFFF to 0 after a preload via forced counter.
